// File: rtl/qspi_pkg.sv
`default_nettype none
// qspi_pkg -- state encoding, SCK/lane constants and shift-count helper for the QSPI lane engine.
// Rev 1.0
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] SCK_ACTIVE = 2'b01;
  localparam logic [1:0] SCK_IDLE   = 2'b00;
  localparam logic [3:0] LANE_SPI   = 4'b0001;
  localparam logic [3:0] LANE_QUAD  = 4'b1111;

  // Shift cycles for a transfer: 8 per byte on one lane, 2 per byte on four lanes.
  function automatic logic [5:0] shift_count(input logic quad, input logic [1:0] len);
    shift_count = quad ? ({3'b000, len, 1'b0} + 6'd2) : ({1'b0, len, 3'b000} + 6'd8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_rd_capture.sv
`default_nettype none
// qspi_rd_capture -- tracks SCK cycles through the pad latency and shifts returned lane bits into the read word.
// Rev 1.0
module qspi_rd_capture
  import qspi_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic        i_quad,
  input  logic [7:0]  i_qdat_v,
  output logic [31:0] o_data
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [31:0]       data_q, data_d;
  logic              unused_even_bits;

  assign unused_even_bits = ^{i_qdat_v[6], i_qdat_v[4], i_qdat_v[2], i_qdat_v[0]};

  generate
    if (RD_LAT == 1) begin : g_vld_single
      always_comb vld_d = i_shift;
    end else begin : g_vld_chain
      always_comb vld_d = {vld_q[RD_LAT-2:0], i_shift};
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (i_clr) begin
      data_d = '0;
    end else if (vld_q[RD_LAT-1]) begin
      data_d = i_quad ? {data_q[27:0], i_qdat_v[7], i_qdat_v[5], i_qdat_v[3], i_qdat_v[1]}
                      : {data_q[30:0], i_qdat_v[3]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule
`default_nettype wire

// File: rtl/qspi_lane_engine.sv
`default_nettype none
// qspi_lane_engine -- QSPI/SPI transfer engine driving DDR pad pairs for SCK and four data lanes.
// Rev 1.0
module qspi_lane_engine
  import qspi_pkg::*;
#(
  parameter int RD_LAT      = 2,
  parameter int CS_HIGH_MIN = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stb,
  input  logic        i_quad,
  input  logic        i_rd,
  input  logic [1:0]  i_len,
  input  logic        i_hold,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_cs_n,
  output logic [1:0]  o_sck_v,
  output logic [7:0]  o_qdat_v,
  output logic [3:0]  o_qdat_oe,
  input  logic [7:0]  i_qdat_v
);

  localparam int            CSW       = (CS_HIGH_MIN < 1) ? 1 : $clog2(CS_HIGH_MIN + 1);
  localparam logic [CSW-1:0] CSHI_LOAD = CSW'(CS_HIGH_MIN);

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [CSW-1:0] cshi_q, cshi_d;
  logic           quad_q, quad_d, rd_q, rd_d, hold_q, hold_d;
  logic [31:0]    data_q, data_d;
  logic           cs_n_q, cs_n_d, busy_q, busy_d, ack_q, ack_d;
  logic [1:0]     sck_q, sck_d;
  logic [7:0]     qdat_q, qdat_d;
  logic [3:0]     oe_q, oe_d;
  logic           accept;
  logic [31:0]    src;
  logic           src_quad, src_rd;
  logic [3:0]     lanes;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cshi_d   = (cs_n_q && (cshi_q != '0)) ? cshi_q - 1'b1 : cshi_q;
    quad_d   = quad_q;
    rd_d     = rd_q;
    hold_d   = hold_q;
    data_d   = data_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    sck_d    = SCK_IDLE;
    qdat_d   = '0;
    oe_d     = '0;
    accept   = 1'b0;
    src      = data_q;
    src_quad = quad_q;
    src_rd   = rd_q;
    lanes    = '0;

    case (state_q)
      IDLE: begin
        if (i_stb) begin
          accept   = 1'b1;
          quad_d   = i_quad;
          rd_d     = i_rd;
          hold_d   = i_hold;
          data_d   = i_data;
          busy_d   = 1'b1;
          cnt_d    = shift_count(i_quad, i_len);
          src      = i_data;
          src_quad = i_quad;
          src_rd   = i_rd;
          state_d  = cs_n_q ? SETUP : SHIFT;
        end
      end
      // CS drops one full cycle before the first SCK edge.
      SETUP: begin
        if (!cs_n_q) begin
          state_d = SHIFT;
        end else if (cshi_q == '0) begin
          cs_n_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == 6'd1) begin
          state_d = rd_q ? DRAIN : DONE;
          cnt_d   = 6'(RD_LAT);
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == 6'd1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin outputs are registered, so they are decoded from the next state.
    if (state_d == SHIFT) begin
      sck_d = SCK_ACTIVE;
      if (!src_rd) begin
        if (src_quad) begin
          lanes  = src[31:28];
          oe_d   = LANE_QUAD;
          data_d = src << 4;
        end else begin
          lanes  = {3'b000, src[31]};
          oe_d   = LANE_SPI;
          data_d = src << 1;
        end
        for (int k = 0; k < 4; k++) begin
          qdat_d[2*k +: 2] = {2{lanes[k]}};
        end
      end
    end

    if (state_d == DONE) begin
      ack_d  = 1'b1;
      busy_d = 1'b0;
      if (!hold_q) begin
        cs_n_d = 1'b1;
        cshi_d = CSHI_LOAD;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cshi_q  <= CSHI_LOAD;
      quad_q  <= 1'b0;
      rd_q    <= 1'b0;
      hold_q  <= 1'b0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      sck_q   <= SCK_IDLE;
      qdat_q  <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cshi_q  <= cshi_d;
      quad_q  <= quad_d;
      rd_q    <= rd_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      sck_q   <= sck_d;
      qdat_q  <= qdat_d;
      oe_q    <= oe_d;
    end
  end

  qspi_rd_capture #(
    .RD_LAT (RD_LAT)
  ) u_rd_capture (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (accept),
    .i_shift  ((state_q == SHIFT) && rd_q),
    .i_quad   (quad_q),
    .i_qdat_v (i_qdat_v),
    .o_data   (o_data)
  );

  assign o_busy    = busy_q;
  assign o_ack     = ack_q;
  assign o_cs_n    = cs_n_q;
  assign o_sck_v   = sck_q;
  assign o_qdat_v  = qdat_q;
  assign o_qdat_oe = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_lane_engine.sv
`default_nettype none
// tb_qspi_lane_engine -- directed and random transfers against a pad-level model of the flash lanes.
// Rev 1.0
module tb_qspi_lane_engine;

  localparam int RD_LAT      = 2;
  localparam int CS_HIGH_MIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, quad = 1'b0, rd = 1'b0, hold = 1'b0;
  logic [1:0]  len = 2'd0;
  logic [31:0] wdata = '0;
  logic [7:0]  qin = '0;
  logic        o_busy, o_ack, o_cs_n;
  logic [31:0] o_data;
  logic [1:0]  o_sck_v;
  logic [7:0]  o_qdat_v;
  logic [3:0]  o_qdat_oe;

  always #5 clk = ~clk;

  qspi_lane_engine #(
    .RD_LAT      (RD_LAT),
    .CS_HIGH_MIN (CS_HIGH_MIN)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_stb     (stb),
    .i_quad    (quad),
    .i_rd      (rd),
    .i_len     (len),
    .i_hold    (hold),
    .i_data    (wdata),
    .o_busy    (o_busy),
    .o_ack     (o_ack),
    .o_data    (o_data),
    .o_cs_n    (o_cs_n),
    .o_sck_v   (o_sck_v),
    .o_qdat_v  (o_qdat_v),
    .o_qdat_oe (o_qdat_oe),
    .i_qdat_v  (qin)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flash/pad model: every SCK cycle seen launches one return chunk that shows up RD_LAT cycles later.
  typedef struct {
    int         due;
    logic [7:0] v;
  } ret_t;
  ret_t        retq[$];
  int          cyc = 0;
  logic        cur_rd = 1'b0, cur_quad = 1'b0;
  int          cur_n = 0;
  logic [31:0] cur_ret = '0;
  int          shift_idx = 0;
  logic [7:0]  obs_v[$];
  logic [3:0]  obs_oe[$];
  int          ack_cnt = 0, rises = 0, hi_run = 0, min_hi = 1000;
  int          sck_cs_err = 0, idle_out_err = 0;
  logic        prev_cs = 1'b1;

  function automatic logic [7:0] ret_chunk(input int idx);
    logic [7:0] v;
    logic [3:0] nib;
    v = 8'($urandom);
    if (cur_quad) begin
      nib = cur_ret[4*(cur_n-1-idx) +: 4];
      for (int k = 0; k < 4; k++) v[2*k+1] = nib[k];
    end else begin
      v[3] = cur_ret[cur_n-1-idx];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      qin = retq[0].v;
      void'(retq.pop_front());
    end else begin
      qin = 8'($urandom);
    end
  end

  always @(negedge clk) begin
    if (o_sck_v == 2'b01) begin
      obs_v.push_back(o_qdat_v);
      obs_oe.push_back(o_qdat_oe);
      if (cur_rd) begin
        ret_t r;
        r.due = cyc + RD_LAT;
        r.v   = ret_chunk(shift_idx);
        retq.push_back(r);
      end
      shift_idx++;
      if (o_cs_n !== 1'b0) sck_cs_err++;
    end else if (o_sck_v !== 2'b00 || o_qdat_oe !== 4'h0) begin
      idle_out_err++;
    end
    if (o_ack === 1'b1) ack_cnt++;
    if (o_cs_n === 1'b1 && prev_cs === 1'b0) rises++;
    if (o_cs_n === 1'b1) begin
      hi_run++;
    end else begin
      if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
      hi_run = 0;
    end
    prev_cs = o_cs_n;
  end

  task automatic randomize_req();
    quad  = 1'($urandom);
    rd    = 1'($urandom);
    len   = 2'($urandom);
    hold  = 1'($urandom);
    wdata = $urandom;
  endtask

  // One transfer. poke: cycle index at which a stray request is pulsed while busy (0 = none).
  // poke_done: pulse a request on the ack cycle. chain: skip the trailing idle check.
  task automatic xfer(input logic q, input logic r, input logic [1:0] l, input logic h,
                      input logic [31:0] d, input logic [31:0] ret,
                      input int poke, input logic poke_done, input logic chain);
    int          n, bits, lat, lo, hi, mism, acks0;
    logic        cs_was_high;
    logic [31:0] exp_data;
    logic [7:0]  ev;
    logic [3:0]  nib;
    n    = q ? 2 * (int'(l) + 1) : 8 * (int'(l) + 1);
    bits = 8 * (int'(l) + 1);
    exp_data = r ? ((bits == 32) ? ret : (ret & ((32'h1 << bits) - 32'h1))) : 32'h0;
    @(posedge clk); #1;
    obs_v.delete(); obs_oe.delete();
    shift_idx = 0; cur_rd = r; cur_quad = q; cur_n = n; cur_ret = ret;
    acks0 = ack_cnt;
    cs_was_high = o_cs_n;
    stb = 1'b1; quad = q; rd = r; len = l; hold = h; wdata = d;
    @(posedge clk); #1;
    stb = 1'b0;
    randomize_req();
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (o_ack === 1'b1) break;
      if (lat > 300) begin
        check("ack_timeout", 32'(lat), 32'd0);
        return;
      end
      stb = (lat == poke);
      if (stb) randomize_req();
    end
    stb = 1'b0;
    lo = r ? n + RD_LAT + 1 : n + 1;
    hi = lo;
    if (cs_was_high) begin
      lo = lo + 2;
      hi = lo + CS_HIGH_MIN;
    end
    check("latency_in_range", 32'(lat >= lo && lat <= hi), 32'd1);
    if (!cs_was_high) check("latency_exact", 32'(lat), 32'(lo));
    check("busy_at_ack", 32'(o_busy), 32'd0);
    check("rdata", o_data, exp_data);
    check("cs_after", 32'(o_cs_n), 32'(!h));
    check("shift_count", 32'(obs_v.size()), 32'(n));
    mism = 0;
    for (int j = 0; j < obs_v.size() && j < n; j++) begin
      if (r) begin
        if (obs_oe[j] !== 4'h0) mism++;
      end else begin
        ev = '0;
        if (q) begin
          nib = d[28-4*j +: 4];
          for (int k = 0; k < 4; k++) ev[2*k +: 2] = {2{nib[k]}};
          if (obs_oe[j] !== 4'hF) mism++;
        end else begin
          ev[1:0] = {2{d[31-j]}};
          if (obs_oe[j] !== 4'h1) mism++;
        end
        if (obs_v[j] !== ev) mism++;
      end
    end
    check("lane_mismatches", 32'(mism), 32'd0);
    if (poke_done) begin
      stb = 1'b1;
      randomize_req();
      @(posedge clk); #1;
      stb = 1'b0;
    end
    if (!chain) begin
      @(negedge clk);
      check("idle_after_ack", {30'd0, o_busy, o_ack}, 32'd0);
      check("single_ack", 32'(ack_cnt - acks0), 32'd1);
      check("rdata_stable", o_data, exp_data);
    end
  endtask

  initial begin
    int rises0, acks0, guard;
    logic q, r, h;
    logic [1:0] l;
    logic [31:0] d, ret;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {28'd0, o_cs_n, o_busy, o_ack, 1'b0}, {28'd0, 4'b1000});
    check("reset_pins", {18'd0, o_sck_v, o_qdat_v, o_qdat_oe}, 32'd0);
    check("reset_data", o_data, 32'd0);
    rst_n = 1'b1;

    // Quad write of one byte from CS high.
    xfer(1'b1, 1'b0, 2'd0, 1'b0, 32'hA512_3456, 32'h0, 0, 1'b0, 1'b0);
    // SPI read of two bytes.
    xfer(1'b0, 1'b1, 2'd1, 1'b0, 32'h0, 32'h0000_C3F0, 0, 1'b0, 1'b0);
    // Quad read of four bytes.
    xfer(1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);

    // Hold chaining: CS stays low, no SETUP on the chained transfers.
    xfer(1'b1, 1'b0, 2'd1, 1'b1, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b1);
    rises0 = rises;
    xfer(1'b0, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0000_005A, 0, 1'b0, 1'b1);
    xfer(1'b0, 1'b0, 2'd3, 1'b0, 32'h8C01_F00D, 32'h0, 0, 1'b0, 1'b0);
    check("cs_no_rise_in_chain", 32'(rises - rises0), 32'd1);

    // Stray requests mid-transfer and on the ack cycle, then a back-to-back request.
    xfer(1'b0, 1'b0, 2'd2, 1'b1, 32'hF0E1_D2C3, 32'h0, 5, 1'b1, 1'b0);
    xfer(1'b0, 1'b1, 2'd3, 1'b1, 32'h0, 32'h89AB_CDEF, 7, 1'b0, 1'b1);
    xfer(1'b1, 1'b0, 2'd0, 1'b0, 32'h3C00_0000, 32'h0, 0, 1'b0, 1'b0);

    // Reset in the middle of shifting.
    @(posedge clk); #1;
    obs_v.delete(); obs_oe.delete();
    shift_idx = 0; cur_rd = 1'b0;
    acks0 = ack_cnt;
    stb = 1'b1; quad = 1'b0; rd = 1'b0; len = 2'd3; hold = 1'b0; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    stb = 1'b0;
    guard = 0;
    while (shift_idx < 5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_shift5", 32'(shift_idx), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {28'd0, o_cs_n, o_busy, o_ack, 1'b0}, {28'd0, 4'b1000});
    check("async_reset_pins", {18'd0, o_sck_v, o_qdat_v, o_qdat_oe}, 32'd0);
    check("async_reset_data", o_data, 32'd0);
    repeat (2) @(negedge clk);
    retq.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_ack_after_abort", 32'(ack_cnt - acks0), 32'd0);
    xfer(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h00A1_B2C3, 0, 1'b0, 1'b0);

    // Randomized transfers.
    for (int i = 0; i < 12; i++) begin
      q   = 1'($urandom);
      r   = 1'($urandom);
      l   = 2'($urandom);
      h   = 1'($urandom);
      d   = $urandom;
      ret = $urandom;
      xfer(q, r, l, h, d, ret, int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom));
    end
    xfer(1'b1, 1'b0, 2'd0, 1'b0, 32'h7700_0000, 32'h0, 0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    xfer(1'b0, 1'b0, 2'd0, 1'b0, 32'h5500_0000, 32'h0, 0, 1'b0, 1'b0);

    check("cs_high_min", 32'(min_hi >= CS_HIGH_MIN), 32'd1);
    check("sck_only_with_cs", 32'(sck_cs_err), 32'd0);
    check("quiet_outside_shift", 32'(idle_out_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qspi_lane_engine.md
Name: qspi_lane_engine

Overview:
- Controller-side transfer engine for the QSPI flash data path.
- Serializes command/address/data bytes onto four data lanes and SCK, and deserializes read data coming back from the lanes.
- Pin-side ports are shaped to drive one DDR IO pad cell per lane, plus one for SCK, and to consume those cells' two-sample outputs.
- Sits between the flash controller's word-level request logic and the pad cells.

Parameters:
- RD_LAT, 2: clocks from the shift cycle that drives SCK to the cycle its sampled bit appears on i_qdat_v (pad pipeline depth); legal range 1..4.
- CS_HIGH_MIN, 3: minimum clocks o_cs_n stays high between deselect and the next select.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stb  in  1  transfer request; accepted only when o_busy=0
- i_quad  in  1  1: four lanes, 4 bits/clk; 0: single SPI, out on lane0, in on lane1
- i_rd  in  1  1: read transfer (lanes tri-stated); 0: write transfer
- i_len  in  2  byte count minus one (0..3 gives 1..4 bytes)
- i_hold  in  1  keep CS asserted after this transfer
- i_data  in  32  write data; first byte is [31:24], MSB first
- o_busy  out  1  transfer in progress
- o_ack  out  1  one-cycle completion pulse
- o_data  out  32  read data, right-justified, upper unused bits zero
- o_cs_n  out  1  flash chip select
- o_sck_v  out  2  SCK pad pair; 2'b01 on shift cycles, 2'b00 otherwise
- o_qdat_v  out  8  lane k pair at [2k+1:2k], both bits equal the lane bit
- o_qdat_oe  out  4  per-lane output enable
- i_qdat_v  in  8  lane k samples at [2k+1:2k]; [2k+1] is the one used

Behaviour:
- Reset (async, i_rst_n=0):
  - o_cs_n=1, o_busy=0, o_ack=0, o_data=0, o_sck_v=0, o_qdat_v=0, o_qdat_oe=0.
  - CS-high counter loaded to CS_HIGH_MIN; state IDLE.
  - A reset mid-transfer aborts immediately; no ack is issued.
- States:
  - IDLE: on i_stb, latch all request fields, clear o_data, set o_busy. Go to SETUP if o_cs_n=1, else directly to SHIFT.
  - SETUP: wait until the CS-high counter reaches 0, drive o_cs_n=0 for one cycle, then go to SHIFT.
  - SHIFT: shift count N = 8·(len+1) in SPI mode, 2·(len+1) in quad mode. Each cycle: o_sck_v=2'b01.
    - Write: emit the next MSBs. SPI: bit on lane0 with oe=4'b0001. Quad: nibble on lanes[3:0] with oe=4'b1111.
    - Read: oe=0.
    - After N cycles, a write goes to DONE and a read goes to DRAIN.
  - DRAIN: wait RD_LAT cycles, then go to DONE.
  - DONE: o_ack=1 for one cycle, o_busy drops the same cycle.
    - If latched hold=0: o_cs_n=1 and the CS-high counter restarts.
    - Return to IDLE.
- Read capture:
  - An RD_LAT-deep valid pipeline tracks shift cycles; each valid cycle shifts i_qdat_v[3] (lane1) in SPI mode, or {[7],[5],[3],[1]} in quad mode, into the o_data LSBs.
  - Exactly N samples are captured.
  - o_data is stable and valid from the ack cycle until the next accepted i_stb.
- Timing:
  - Write latency, i_stb to o_ack, with CS already low: N+1 clocks.
  - Read latency with CS already low: N+RD_LAT+1 clocks.
  - Add SETUP cycles when CS starts high.
- Outputs outside SHIFT: o_sck_v=0, o_qdat_oe=0.
- Boundary and error cases:
  - i_stb while busy: ignored, and never queued.
  - i_stb in the same cycle as DONE: ignored; accepted the next cycle.
  - i_stb while the CS-high counter is nonzero: accepted; SETUP stalls until the counter expires.
  - i_len=3 in SPI mode: 32 shift cycles; the counter is 6 bits wide.

Decomposition:
- Shared package qspi_pkg:
  - state enum: IDLE, SETUP, SHIFT, DRAIN, DONE
  - SCK_ACTIVE=2'b01, SCK_IDLE=2'b00
  - lane-mask constants 4'b0001 and 4'b1111
- One sub-module qspi_rd_capture: the RD_LAT valid pipeline plus the mode-dependent input shift register.

Test Plan:
- Quad write, CS high: i_len=0, i_data=32'hA5xx_xxxx → CS low after 3 idle-high clocks, lanes show 4'hA then 4'h5 with oe=4'hF, ack 1 clock later, CS returns high.
- SPI read: i_len=1, RD_LAT=2, bench returns 16'hC3F0 on lane1 → 16 SCK cycles, ack at cycle 16+2+1, o_data=32'h0000C3F0.
- Quad read: i_len=3, bench returns 32'hDEADBEEF on lanes → o_data=32'hDEADBEEF; oe stays 0 throughout.
- Hold chaining: quad write with hold=1, then a read issued right after ack → o_cs_n never rises and there is no SETUP cycle; after a final transfer with hold=0, CS rises and is held high ≥CS_HIGH_MIN.
- Busy/overlap: i_stb pulsed mid-transfer and on the DONE cycle → both ignored; a request issued one clock after ack is accepted.
- Reset mid-SHIFT: i_rst_n low at shift cycle 5 → all outputs reach their reset values asynchronously, no ack; a new transfer after release completes normally.
